// File: rtl/cdc_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the CDC event arbiter.
// The helper works on a fixed 16-bit view so callers with any N_REQ (2..16) can share it.
package cdc_arb_pkg;

    typedef enum logic {IDLE, WAIT_ACK} arb_state_e;

    localparam int DROP_CNT_W = 8;
    localparam int RR_MAX     = 16;
    localparam int RR_W       = 4;

    typedef logic [RR_MAX-1:0] rr_vec_t;
    typedef logic [RR_W-1:0]   rr_idx_t;

    // First set bit at or after ptr, wrapping within n_req; returns ptr when nothing is set.
    function automatic rr_idx_t rr_pick(input rr_vec_t pend, input rr_idx_t ptr,
                                        input int unsigned n_req);
        rr_idx_t     win;
        logic        found;
        int unsigned idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (i < n_req) begin
                idx = 32'(ptr) + i;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                if (!found && pend[idx]) begin
                    win   = rr_idx_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cdc_event_arbiter_if.sv
// Requester/consumer signal bundle of the CDC event arbiter.
// req/gnt/busy/done/drop_cnt belong to clk1; evt/evt_id belong to clk2.
interface cdc_event_arbiter_if
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]      req_i;
    logic [N_REQ-1:0]      gnt_o;
    logic                  busy_o;
    logic                  done_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;
    logic                  evt_o;
    logic [ID_W-1:0]       evt_id_o;

    modport master (
        output req_i,
        input  gnt_o, busy_o, done_o, drop_cnt_o, evt_o, evt_id_o
    );

    modport slave (
        input  req_i,
        output gnt_o, busy_o, done_o, drop_cnt_o, evt_o, evt_id_o
    );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_event_arbiter.sv
// Round-robin arbiter sharing one toggle req/ack CDC channel from clk1 to clk2.
// Optional saturating drop counter enabled by defining CDC_EVT_DROP_CNT_EN.
module cdc_event_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               clk2,
    cdc_event_arbiter_if.slave bus
);
    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  winner;
    logic             req_tgl_q, req_tgl_d;
    logic             ack_sync;
    logic             busy;
    logic             done;

    assign winner = ID_W'(rr_pick(rr_vec_t'(pend_q), rr_idx_t'(ptr_q), N_REQ));

    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        ptr_d     = ptr_q;
        id_d      = id_q;
        req_tgl_d = req_tgl_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    gnt       = N_REQ'(1) << winner;
                    id_d      = winner;
                    req_tgl_d = ~req_tgl_q;
                    ptr_d     = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (ack_sync == req_tgl_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request arriving on its own grant cycle keeps the source pending.
        pend_d = (pend_q & ~gnt) | bus.req_i;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            req_tgl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            req_tgl_q <= req_tgl_d;
        end
    end

    assign bus.gnt_o  = gnt;
    assign bus.busy_o = busy;
    assign bus.done_o = done;

`ifdef CDC_EVT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  drop_hit;

    assign drop_hit = |(bus.req_i & pend_q & ~gnt);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_hit && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`else
    assign bus.drop_cnt_o = '0;
`endif

    // clk2 side. id_q crosses as a bus without synchronizers: it is held from
    // launch until done, so constrain it as a false path / max-delay.
    logic            req_sync;
    logic            req_seen_q;
    logic            req_chg;
    logic            evt_q;
    logic [ID_W-1:0] evt_id_q;
    logic            ack_tgl_q;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk2),
        .rst (rst),
        .d_i (req_tgl_q),
        .q_o (req_sync)
    );

    assign req_chg = req_sync ^ req_seen_q;

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            req_seen_q <= 1'b0;
            evt_q      <= 1'b0;
            evt_id_q   <= '0;
            ack_tgl_q  <= 1'b0;
        end else begin
            req_seen_q <= req_sync;
            evt_q      <= req_chg;
            if (req_chg) begin
                evt_id_q  <= id_q;
                ack_tgl_q <= req_sync;
            end
        end
    end

    assign bus.evt_o    = evt_q;
    assign bus.evt_id_o = evt_id_q;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk1),
        .rst (rst),
        .d_i (ack_tgl_q),
        .q_o (ack_sync)
    );

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Directed self-checking bench for cdc_event_arbiter (N_REQ=4) at clk2 = 3x and 1/3x clk1.
// Drop-count expectation follows CDC_EVT_DROP_CNT_EN.
module tb_cdc_event_arbiter;
    import cdc_arb_pkg::*;

    localparam int N_REQ       = 4;
    localparam int ID_W        = 2;
    localparam int SYNC_STAGES = 2;

    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic rst  = 1'b1;
    int   hp2  = 5;

    int n_cmp = 0;
    int n_bad = 0;
    int evt_cnt = 0;
    int done_cnt = 0;
    int gnt_cnt = 0;
    int gnt_bad = 0;
    int unsigned evt_ids[$];

    cdc_event_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    cdc_event_arbiter #(
        .N_REQ       (N_REQ),
        .ID_W        (ID_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .clk2 (clk2),
        .bus  (bus)
    );

    always #15 clk1 = ~clk1;

    initial begin
        #7;
        forever begin
            #(hp2) clk2 = ~clk2;
        end
    end

    always @(negedge clk2) begin
        if (!rst && bus.evt_o) begin
            evt_cnt++;
            evt_ids.push_back(32'(bus.evt_id_o));
            $display("[%0t] evt id=%0d", $time, bus.evt_id_o);
        end
    end

    always @(negedge clk1) begin
        if (!rst) begin
            if (bus.done_o) done_cnt++;
            if (|bus.gnt_o) begin
                gnt_cnt++;
                if ($countones(bus.gnt_o) != 1) gnt_bad++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    function automatic int unsigned id_at(input int i);
        return (evt_ids.size() > i) ? evt_ids[i] : 99;
    endfunction

    task automatic clear_counts();
        evt_cnt  = 0;
        done_cnt = 0;
        gnt_cnt  = 0;
        evt_ids.delete();
    endtask

    task automatic do_reset(input int new_hp2);
        rst       = 1'b1;
        bus.req_i = '0;
        hp2       = new_hp2;
        cyc(6);
        clear_counts();
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic pulse(input logic [N_REQ-1:0] v);
        bus.req_i = v;
        cyc(1);
        bus.req_i = '0;
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 20 && t < 3000) begin
            cyc(1);
            t++;
            if (bus.busy_o || (|bus.gnt_o)) quiet = 0;
            else quiet++;
        end
        check({tag, "_drained"}, 32'(quiet >= 20), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},    32'(bus.gnt_o), 0);
        check({tag, "_busy"},   32'(bus.busy_o), 0);
        check({tag, "_done"},   32'(bus.done_o), 0);
        check({tag, "_evt"},    32'(bus.evt_o), 0);
        check({tag, "_evt_id"}, 32'(bus.evt_id_o), 0);
        check({tag, "_drop"},   32'(bus.drop_cnt_o), 0);
    endtask

    initial begin
        int unsigned drop_exp;
        int alt_err;
        int zeros;
        int t;
`ifdef CDC_EVT_DROP_CNT_EN
        drop_exp = 4;
`else
        drop_exp = 0;
`endif
        bus.req_i = '0;

        // Reset state
        cyc(3);
        check_outputs_zero("rst");
        rst = 1'b0;
        cyc(2);

        // Single pulse on source 2
        bus.req_i = 4'b0100;
        cyc(1);
        bus.req_i = '0;
        check("single_gnt", 32'(bus.gnt_o), 32'h4);
        check("single_busy_pre", 32'(bus.busy_o), 0);
        cyc(1);
        check("single_busy", 32'(bus.busy_o), 1);
        drain("single");
        check("single_evt_cnt", 32'(evt_cnt), 1);
        check("single_id", id_at(0), 2);
        check("single_done_cnt", 32'(done_cnt), 1);
        check("single_busy_post", 32'(bus.busy_o), 0);

        // All four at once from ptr=0, clk2 = 3x clk1
        do_reset(5);
        pulse(4'b1111);
        drain("all4");
        check("all4_evt_cnt", 32'(evt_cnt), 4);
        check("all4_done_cnt", 32'(done_cnt), 4);
        check("all4_gnt_cnt", 32'(gnt_cnt), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("all4_id%0d", i), id_at(i), 32'(i));
        end

        // Fairness with sources 0 and 3 held high
        clear_counts();
        bus.req_i = 4'b1001;
        t = 0;
        while (evt_cnt < 40 && t < 5000) begin
            cyc(1);
            t++;
        end
        bus.req_i = '0;
        check("fair_reached40", 32'(evt_cnt >= 40), 1);
        drain("fair");
        alt_err = 0;
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            if (id_at(i) != ((i % 2 == 0) ? 32'd0 : 32'd3)) alt_err++;
            if (id_at(i) == 0) zeros++;
        end
        check("fair_alt_errors", 32'(alt_err), 0);
        check("fair_src0_share", 32'(zeros), 20);
        check("fair_evt_eq_gnt", 32'(evt_cnt), 32'(gnt_cnt));
        check("fair_done_eq_gnt", 32'(done_cnt), 32'(gnt_cnt));

        // clk2 = 1/3 clk1, unrelated phase
        do_reset(45);
        pulse(4'b1111);
        drain("slow_all4");
        pulse(4'b1010);
        drain("slow_1010");
        check("slow_evt_cnt", 32'(evt_cnt), 6);
        check("slow_done_cnt", 32'(done_cnt), 6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("slow_id%0d", i), id_at(i), 32'(i));
        end
        check("slow_id4", id_at(4), 1);
        check("slow_id5", id_at(5), 3);

        // Reset while a handshake is in flight
        do_reset(45);
        pulse(4'b0001);
        cyc(1);
        check("midrst_busy", 32'(bus.busy_o), 1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_outputs_zero("midrst_in");
        cyc(6);
        clear_counts();
        rst = 1'b0;
        cyc(40);
        check("midrst_no_evt", 32'(evt_cnt), 0);
        check("midrst_no_gnt", 32'(gnt_cnt), 0);
        pulse(4'b0001);
        drain("midrst_new");
        check("midrst_new_cnt", 32'(evt_cnt), 1);
        check("midrst_new_id", id_at(0), 0);

        // Drop counting: source 1 re-requested while already pending and channel busy
        do_reset(45);
        bus.req_i = 4'b0001;
        cyc(1);
        bus.req_i = 4'b0010;
        cyc(5);
        bus.req_i = '0;
        check("drop_busy", 32'(bus.busy_o), 1);
        drain("drop");
        check("drop_cnt", 32'(bus.drop_cnt_o), drop_exp);
        check("drop_id0", id_at(0), 0);
        check("drop_id1", id_at(1), 1);
        check("drop_evt_cnt", 32'(evt_cnt), 2);

        check("gnt_onehot_viol", 32'(gnt_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
